// File: rtl/noc_local_ingress_fifo_pkg.sv
// Shared definitions for the local ingress flit buffer: data width, sideband layout,
// framer state encodings and a small saturating-counter helper.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_local_ingress_fifo_pkg;

    localparam int NOC_DATA_WIDTH = `Noc_Data_Width;
    localparam int NOC_SIDEBAND_W = 2;
    localparam int NOC_ENTRY_W    = NOC_DATA_WIDTH + NOC_SIDEBAND_W;

    localparam logic [0:0] FR_IDLE   = 1'b0;
    localparam logic [0:0] FR_IN_PKT = 1'b1;

    typedef struct packed {
        logic                      is_header;
        logic                      is_tail;
        logic [NOC_DATA_WIDTH-1:0] flit;
    } noc_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is read straight from
// registered storage, so a write at edge N is visible at the output after edge N.
module noc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             noc_clk,
    input  logic             noc_rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    // A full FIFO never takes a write, even if the head is leaving this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/noc_local_ingress_fifo.sv
// Local ingress flit buffer: packet framer, packet/error counters and optional
// store-and-forward release in front of a FWFT FIFO.
//   state  | meaning
//   IDLE   | between packets; only a header flit starts a packet
//   IN_PKT | header accepted, waiting for the tail
module noc_local_ingress_fifo
    import noc_local_ingress_fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int STORE_FWD = 0
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NOC_DATA_WIDTH-1:0] in_flit,
    input  logic                      in_is_header,
    input  logic                      in_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NOC_DATA_WIDTH-1:0] out_flit,
    output logic                      out_is_header,
    output logic                      out_is_tail,
    output logic [15:0]               pkt_cnt,
    output logic                      frame_err,
    output logic [7:0]                err_cnt
);
    localparam int TW = $clog2(DEPTH) + 1;
    localparam logic [TW-1:0] T_ONE = TW'(1);

    logic [0:0]    state_q, state_d;
    logic          hs, accept, err_ev;
    logic          pop, tail_push, tail_pop, full, empty, release_ok;
    logic [TW-1:0] tails_q;
    logic          rel_q;
    logic [15:0]   pkt_cnt_q;
    logic [7:0]    err_cnt_q;
    logic          frame_err_q;
    noc_entry_t    wr_entry, head;

    assign hs = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_ev  = 1'b0;
        if (hs) begin
            case (state_q)
                FR_IDLE: begin
                    if (in_is_header) begin
                        accept  = 1'b1;
                        state_d = in_is_tail ? FR_IDLE : FR_IN_PKT;
                    end else begin
                        err_ev = 1'b1;
                    end
                end
                default: begin
                    // A header here means the previous tail went missing; keep it anyway.
                    accept = 1'b1;
                    if (in_is_header) err_ev = 1'b1;
                    if (in_is_tail) state_d = FR_IDLE;
                end
            endcase
        end
    end

    assign wr_entry = '{is_header: in_is_header, is_tail: in_is_tail, flit: in_flit};

    noc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NOC_ENTRY_W)
    ) u_fifo (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .push_i    (accept),
        .wdata_i   (wr_entry),
        .pop_i     (pop),
        .rdata_o   (head),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign tail_push = accept && in_is_tail;
    assign tail_pop  = pop && head.is_tail;

    // Full releases over-long packets; rel_q keeps a partly drained packet flowing.
    assign release_ok = (STORE_FWD == 0) || (tails_q != '0) || full || rel_q;

    assign in_ready      = !full;
    assign out_valid     = !empty && release_ok;
    assign pop           = out_valid && out_ready;
    assign out_flit      = head.flit;
    assign out_is_header = head.is_header;
    assign out_is_tail   = head.is_tail;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign frame_err     = frame_err_q;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= FR_IDLE;
            tails_q     <= '0;
            rel_q       <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= err_ev;
            if (err_ev) err_cnt_q <= sat_inc8(err_cnt_q);
            if (tail_push) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (tail_push && !tail_pop)      tails_q <= tails_q + T_ONE;
            else if (tail_pop && !tail_push) tails_q <= tails_q - T_ONE;
            if (pop) rel_q <= !head.is_tail;
        end
    end

endmodule

// File: tb/tb_noc_local_ingress_fifo.sv
// Bench for the local ingress FIFO: a cut-through and a store-and-forward instance,
// each tracked by a queue-based packet model and checked every cycle.
module tb_noc_local_ingress_fifo;
    import noc_local_ingress_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = NOC_DATA_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   iv, ih, it, ordy;
    logic [1:0]   ird, ov, oh, ot, fe;
    logic [W-1:0] iflit [2];
    logic [W-1:0] of [2];
    logic [15:0]  pc [2];
    logic [7:0]   ec [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        noc_local_ingress_fifo #(
            .DEPTH     (DEPTH),
            .STORE_FWD (k)
        ) dut (
            .noc_clk       (clk),
            .noc_rst_n     (rst_n),
            .in_valid      (iv[k]),
            .in_ready      (ird[k]),
            .in_flit       (iflit[k]),
            .in_is_header  (ih[k]),
            .in_is_tail    (it[k]),
            .out_valid     (ov[k]),
            .out_ready     (ordy[k]),
            .out_flit      (of[k]),
            .out_is_header (oh[k]),
            .out_is_tail   (ot[k]),
            .pkt_cnt       (pc[k]),
            .frame_err     (fe[k]),
            .err_cnt       (ec[k])
        );

        noc_entry_t q[$];
        noc_entry_t e;
        bit in_pkt, rel, ferr, mv, hs, pop, err_now, has_tail;
        int pkt, err;

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete();
                    in_pkt = 0; rel = 0; ferr = 0; pkt = 0; err = 0;
                end else begin
                    hs      = iv[k] && (q.size() < DEPTH);
                    pop     = mv && ordy[k];
                    err_now = 0;
                    if (pop) begin
                        e   = q.pop_front();
                        rel = !e.is_tail;
                    end
                    if (hs) begin
                        e = '{is_header: ih[k], is_tail: it[k], flit: iflit[k]};
                        if (!in_pkt && !ih[k]) begin
                            err_now = 1;
                        end else begin
                            q.push_back(e);
                            if (in_pkt && ih[k]) err_now = 1;
                            if (it[k]) begin
                                pkt    = (pkt + 1) % 65536;
                                in_pkt = 0;
                            end else begin
                                in_pkt = 1;
                            end
                        end
                    end
                    if (err_now && err < 255) err++;
                    ferr = err_now;
                end
                has_tail = 0;
                foreach (q[i]) if (q[i].is_tail) has_tail = 1;
                mv = (q.size() > 0) && (k == 0 || rel || has_tail || q.size() == DEPTH);
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                chk($sformatf("in_ready[%0d]", k), 64'(ird[k]), 64'(q.size() < DEPTH));
                chk($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(mv));
                if (mv) begin
                    chk($sformatf("out_flit[%0d]", k), 64'(of[k]), 64'(q[0].flit));
                    chk($sformatf("out_hdr[%0d]", k), 64'(oh[k]), 64'(q[0].is_header));
                    chk($sformatf("out_tail[%0d]", k), 64'(ot[k]), 64'(q[0].is_tail));
                end
                if (!rst_n) begin
                    chk($sformatf("rst_out_flit[%0d]", k), 64'(of[k]), 64'(0));
                    chk($sformatf("rst_out_flags[%0d]", k), 64'({oh[k], ot[k]}), 64'(0));
                end
                chk($sformatf("pkt_cnt[%0d]", k), 64'(pc[k]), 64'(pkt));
                chk($sformatf("err_cnt[%0d]", k), 64'(ec[k]), 64'(err));
                chk($sformatf("frame_err[%0d]", k), 64'(fe[k]), 64'(ferr));
            end
        end
    end

    task automatic send(input int k, input logic [W-1:0] f, input logic h, input logic t);
        bit done;
        done     = 0;
        iv[k]    = 1'b1;
        iflit[k] = f;
        ih[k]    = h;
        it[k]    = t;
        for (int c = 0; c < 50 && !done; c++) begin
            done = ird[k];
            @(posedge clk);
            #1;
        end
        chk("send_handshake", 64'(done), 64'(1));
    endtask

    task automatic idle(input int k, input int n);
        iv[k] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        iv = '0; ih = '0; it = '0; ordy = '0;
        iflit[0] = '0; iflit[1] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(ov[0]), 64'(0));
        chk("reset_in_ready", 64'(ird[0]), 64'(1));
        chk("reset_pkt_cnt", 64'(pc[0]), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-flit packet, cut-through
        ordy[0] = 1'b1;
        send(0, 'hA1, 1'b1, 1'b0);
        chk("t1_h_valid", 64'(ov[0]), 64'(1));
        chk("t1_h_flit", 64'(of[0]), 64'hA1);
        chk("t1_h_hdr", 64'(oh[0]), 64'(1));
        send(0, 'hA2, 1'b0, 1'b0);
        chk("t1_d_flit", 64'(of[0]), 64'hA2);
        send(0, 'hA3, 1'b0, 1'b1);
        chk("t1_t_flit", 64'(of[0]), 64'hA3);
        chk("t1_t_tail", 64'(ot[0]), 64'(1));
        idle(0, 2);
        chk("t1_pkt_cnt", 64'(pc[0]), 64'(1));
        chk("t1_drained", 64'(ov[0]), 64'(0));

        // Fill to DEPTH with out_ready low, hold, then drain
        ordy[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, W'('hB0 + i), 1'(i == 0), 1'(i == 7));
        iv[0] = 1'b0;
        chk("t2_full_ready", 64'(ird[0]), 64'(0));
        idle(0, 5);
        chk("t2_hold_ready", 64'(ird[0]), 64'(0));
        chk("t2_hold_flit", 64'(of[0]), 64'hB0);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_ready_after_pop", 64'(ird[0]), 64'(1));
        chk("t2_second_flit", 64'(of[0]), 64'hB1);
        idle(0, 10);
        chk("t2_pkt_cnt", 64'(pc[0]), 64'(2));

        // Out-of-packet data flits are dropped
        send(0, 'hC0, 1'b0, 1'b0);
        chk("t3_frame_err", 64'(fe[0]), 64'(1));
        chk("t3_err_cnt", 64'(ec[0]), 64'(1));
        chk("t3_empty", 64'(ov[0]), 64'(0));
        idle(0, 1);
        chk("t3_err_pulse_end", 64'(fe[0]), 64'(0));
        for (int i = 0; i < 300; i++) send(0, W'(i), 1'b0, 1'b0);
        idle(0, 2);
        chk("t3_err_sat", 64'(ec[0]), 64'd255);
        chk("t3_still_empty", 64'(ov[0]), 64'(0));

        // Store-and-forward holds H,D,D until T arrives
        ordy[1] = 1'b1;
        send(1, 'hD0, 1'b1, 1'b0);
        send(1, 'hD1, 1'b0, 1'b0);
        send(1, 'hD2, 1'b0, 1'b0);
        iv[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_held", 64'(ov[1]), 64'(0));
            @(posedge clk);
            #1;
        end
        send(1, 'hD3, 1'b0, 1'b1);
        iv[1] = 1'b0;
        chk("t4_released", 64'(ov[1]), 64'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_burst_valid", 64'(ov[1]), 64'(1));
            chk("t4_burst_flit", 64'(of[1]), 64'('hD0 + i));
        end
        @(negedge clk);
        chk("t4_after_burst", 64'(ov[1]), 64'(0));

        // Single-flit packet pushed while a tail pops
        @(posedge clk);
        #1;
        ordy[1] = 1'b0;
        send(1, 'hE0, 1'b1, 1'b1);
        iv[1] = 1'b0;
        chk("t5_first_valid", 64'(ov[1]), 64'(1));
        ordy[1] = 1'b1;
        send(1, 'hE1, 1'b1, 1'b1);
        iv[1] = 1'b0;
        chk("t5_still_valid", 64'(ov[1]), 64'(1));
        chk("t5_flit", 64'(of[1]), 64'hE1);
        chk("t5_pkt_cnt", 64'(pc[1]), 64'(3));
        @(posedge clk);
        #1;
        chk("t5_drained", 64'(ov[1]), 64'(0));

        // Reset with 5 flits buffered mid-packet
        ordy[0] = 1'b0;
        send(0, 'hF0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(0, W'('hF0 + i), 1'b0, 1'b0);
        iv[0] = 1'b0;
        chk("t6_buffered", 64'(ov[0]), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(ov[0]), 64'(0));
        chk("t6_rst_pkt_cnt", 64'(pc[0]), 64'(0));
        chk("t6_rst_err_cnt", 64'(ec[0]), 64'(0));
        chk("t6_rst_ready", 64'(ird[0]), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        send(0, 'hF9, 1'b1, 1'b1);
        iv[0] = 1'b0;
        chk("t6_new_valid", 64'(ov[0]), 64'(1));
        chk("t6_new_flit", 64'(of[0]), 64'hF9);
        idle(0, 2);
        chk("t6_new_pkt_cnt", 64'(pc[0]), 64'(1));

        idle(0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
